mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single instruction/data memory port between Icache line refill and Dcache line refill/writeback.
//  Sits between both caches and the memory model; the port handles one transaction at a time.
//  Runs each transaction as a LINE_WORDS-beat burst and paces beats with mem_ready_i.
//  Dcache has priority; a starvation counter guarantees Icache progress.
// PARAMETERS
//  LINE_WORDS    4   words per cache line / beats per burst (power of 2, >=2)
//  STARVE_LIMIT  3   consecutive lost Icache arbitrations before Icache is forced to win
//  ADDR_W        32  address width (byte address)
//  DATA_W        32  word width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  ic_req_i     in   1       Icache refill request, held until ic_done_o
//  ic_addr_i    in   ADDR_W  Icache miss address (any byte in line)
//  ic_gnt_o     out  1       1-cycle pulse: Icache burst started
//  ic_rvalid_o  out  1       ic_rdata_o word valid this cycle
//  ic_rdata_o   out  DATA_W  refill word, beats in ascending address order
//  ic_done_o    out  1       1-cycle pulse after the last beat
//  dc_req_i     in   1       Dcache request, held until dc_done_o
//  dc_we_i      in   1       1=writeback burst, 0=refill burst; stable with dc_req_i
//  dc_addr_i    in   ADDR_W  Dcache line address
//  dc_wdata_i   in   DATA_W  writeback word for the current beat
//  dc_gnt_o     out  1       1-cycle pulse: Dcache burst started
//  dc_rvalid_o  out  1       dc_rdata_o valid (refill only)
//  dc_rdata_o   out  DATA_W  refill word
//  dc_wready_o  out  1       dc_wdata_i consumed this cycle; Dcache advances to the next word
//  dc_done_o    out  1       1-cycle pulse after the last beat
//  mem_req_o    out  1       beat request to memory
//  mem_we_o     out  1       beat is a write
//  mem_addr_o   out  ADDR_W  beat address
//  mem_wdata_o  out  DATA_W  beat write data (= dc_wdata_i during a writeback)
//  mem_ready_i  in   1       memory completes the beat this cycle
//  mem_rdata_i  in   DATA_W  read data, valid with mem_ready_i
// BEHAVIOUR
//  Reset: FSM=IDLE, beat=0, starve=0, owner=none. All outputs are 0.
//  FSM states: IDLE -> BURST -> DONE -> IDLE.
//  IDLE: arbitration runs only in IDLE.
//   - Dcache wins if dc_req_i=1, unless (ic_req_i=1 and starve==STARVE_LIMIT); then Icache wins.
//   - On a win: latch owner, we and line base = addr & ~(LINE_WORDS*4-1); pulse gnt; go to BURST.
//   - starve: +1 when both request and Dcache wins (saturates); cleared when Icache wins.
//     Unchanged in all other cases.
//  BURST:
//   - mem_req_o=1, mem_we_o=latched we (Icache: always 0), mem_addr_o=base+beat*4.
//   - First beat is issued the cycle after gnt.
//   - A beat completes in a cycle with mem_ready_i=1. On completion:
//     read -> owner rvalid=1 and rdata=mem_rdata_i (combinational pass-through);
//     write -> dc_wready_o=1.
//   - The beat counter wraps at LINE_WORDS. The last completion goes to DONE.
//   - mem_ready_i=0 holds the beat with no limit; address and data stay stable.
//  DONE: mem_req_o=0; owner done pulse; next state IDLE.
//   - Minimum port occupancy is LINE_WORDS+2 cycles, with at least 1 idle cycle between bursts.
//  Request rules:
//   - A requester dropping req mid-burst does not stop the burst; it runs to completion. This is flagged by an assertion.
//   - The non-owner's req is ignored until IDLE.
//   - Simultaneous requests in IDLE are resolved by the priority rule above. Never both gnt.
//  Side-band rules:
//   - mem_ready_i while mem_req_o=0 is ignored.
//   - The owner's addr/we changing mid-burst has no effect, because both are latched at grant.
//  Reset mid-burst: everything returns to the reset state immediately. No done pulse; the burst is abandoned.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/BURST/DONE), owner encoding (NONE/IC/DC), WORD_BYTES=4.
//  Sub-module mem_arb_pick: priority decision plus the saturating starvation counter.
//   Inputs: ic_req, dc_req, arb_en (FSM in IDLE). Outputs: pick_ic, pick_dc.
//  Top level holds the FSM, beat counter, latched base/we, and the output muxing.
// TESTING
//  1. Icache-only req addr 0x0000_0014, mem_ready_i always 1
//     -> gnt at T+0; beats at 0x10,0x14,0x18,0x1C on T+1..T+4; ic_done_o at T+5.
//  2. Dcache writeback addr 0x100, wdata 0xA0..0xA3, mem_ready_i every other cycle
//     -> 4 writes at 0x100..0x10C with matching data; dc_wready_o 4 times; dc_done_o once.
//  3. Both request continuously
//     -> grant order DC,DC,DC,IC,DC,DC,DC,IC; no cycle has both gnts or both rvalids.
//  4. Dcache refill with mem_ready_i low 5 cycles on beat 2
//     -> mem_addr_o holds base+8 for the stall; dc_rvalid_o exactly 4 times.
//  5. rst_n asserted during beat 1 of an Icache burst
//     -> all outputs 0 at once; after release, a new dc_req_i is granted from IDLE.
//  6. Icache drops ic_req_i after beat 0
//     -> burst completes all 4 beats; assertion fires; next arbitration proceeds normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM/owner encodings for the memory port arbiter
package mem_bus_arbiter_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] O_NONE  = 2'd0;
  localparam logic [1:0] O_IC    = 2'd1;
  localparam logic [1:0] O_DC    = 2'd2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: Dcache-priority pick with a saturating starvation override for Icache
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ic_req,
  input  logic dc_req,
  input  logic arb_en,
  output logic pick_ic,
  output logic pick_dc
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve;
  logic starved;
  assign starved = starve == SW'(STARVE_LIMIT);
  assign pick_ic = arb_en && ic_req && (!dc_req || starved);
  assign pick_dc = arb_en && dc_req && !pick_ic;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else if (pick_ic) starve <= '0;
    else if (pick_dc && ic_req && !starved) starve <= starve + 1'b1;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between Icache refill and Dcache refill/writeback bursts
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS   = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_wready_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int BW = $clog2(LINE_WORDS);
  logic [1:0] state, owner;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] base;
  logic we, pick_ic, pick_dc, burst, fire, last;
  // gating arb_en with rst_n keeps the combinational grants quiet while reset is held
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk(clk),
    .rst_n(rst_n),
    .ic_req(ic_req_i),
    .dc_req(dc_req_i),
    .arb_en(rst_n && state == S_IDLE),
    .pick_ic(pick_ic),
    .pick_dc(pick_dc)
  );
  assign burst = state == S_BURST;
  assign fire = burst && mem_ready_i;
  assign last = beat == BW'(LINE_WORDS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= O_NONE;
      beat  <= '0;
      base  <= '0;
      we    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (pick_ic || pick_dc) begin
        state <= S_BURST;
        owner <= pick_ic ? O_IC : O_DC;
        we    <= pick_dc && dc_we_i;
        base  <= (pick_ic ? ic_addr_i : dc_addr_i) & ~ADDR_W'(LINE_WORDS * WORD_BYTES - 1);
      end
    end else if (burst) begin
      if (fire) begin
        beat <= beat + 1'b1;
        if (last) state <= S_DONE;
      end
    end else begin
      state <= S_IDLE;
      owner <= O_NONE;
    end
  assign ic_gnt_o    = pick_ic;
  assign dc_gnt_o    = pick_dc;
  assign mem_req_o   = burst;
  assign mem_we_o    = burst && we;
  assign mem_addr_o  = burst ? base + ADDR_W'(beat) * ADDR_W'(WORD_BYTES) : '0;
  assign mem_wdata_o = mem_we_o ? dc_wdata_i : '0;
  assign ic_rvalid_o = fire && owner == O_IC;
  assign dc_rvalid_o = fire && owner == O_DC && !we;
  assign dc_wready_o = fire && we;
  assign ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
  assign dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;
  assign ic_done_o   = state == S_DONE && owner == O_IC;
  assign dc_done_o   = state == S_DONE && owner == O_DC;
  // a burst always runs to completion; losing the owner's request mid-way is only reported
  always_ff @(posedge clk)
    if (rst_n && burst)
      assert (owner == O_IC ? ic_req_i : dc_req_i)
        else $warning("owner released its request mid-burst; burst continues");
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a beat/grant/done scoreboard for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 0, rst_n = 0;
  logic ic_req_i = 0, dc_req_i = 0, dc_we_i = 0, mem_ready_i = 1;
  logic [31:0] ic_addr_i = 0, dc_addr_i = 0, dc_wdata_i = 32'hA0;
  logic ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o, dc_wready_o, dc_done_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] ic_rdata_o, dc_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .dc_wready_o(dc_wready_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  assign mem_rdata_i = mem_addr_o ^ 32'h5A5A_0000;

  typedef struct {int own; logic we; logic [31:0] addr; logic [31:0] wdata;} beat_t;
  beat_t beat_q[$];
  int gnt_q[$], done_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, beats_done = 0, done_cnt = 0, wr_cnt = 0, dc_rv_cnt = 0;
  int gnt_cyc = 0, done_cyc = 0, first_beat_cyc = -1;
  int ready_mode = 0, stall_at = -1, stall_n = 0, stall_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int own, input logic we, input logic [31:0] addr);
    for (int i = 0; i < 4; i++) beat_q.push_back('{own, we, (addr & ~32'hF) + 32'(4 * i), 32'hA0 + 32'(i)});
    gnt_q.push_back(own);
    done_q.push_back(own);
  endtask

  task automatic wait_dones(input int n);
    int target = done_cnt + n;
    for (int i = 0; i < 300 && done_cnt < target; i++) begin @(posedge clk); #2; end
    chk("done_count", done_cnt, target);
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 300 && beats_done < target; i++) begin @(posedge clk); #2; end
    chk("beat_count", beats_done, target);
  endtask

  // memory pacing and writeback data source
  always @(posedge clk) begin
    cyc++;
    #1;
    if (ready_mode == 1) mem_ready_i = cyc[0];
    else if (ready_mode == 2 && beats_done == stall_at && stall_n < 5) begin
      mem_ready_i = 0;
      stall_n++;
    end else mem_ready_i = 1;
    dc_wdata_i = 32'hA0 + 32'(wr_cnt);
  end

  // monitor/scoreboard
  always @(negedge clk) if (rst_n) begin
    chk("gnt_excl", 32'(ic_gnt_o & dc_gnt_o), 0);
    chk("rvalid_excl", 32'(ic_rvalid_o & dc_rvalid_o), 0);
    if (ic_gnt_o || dc_gnt_o) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", ic_gnt_o ? 1 : 2, 0);
      else chk("gnt_owner", ic_gnt_o ? 1 : 2, gnt_q.pop_front());
      gnt_cyc = cyc;
      first_beat_cyc = -1;
    end
    if (ic_done_o || dc_done_o) begin
      if (done_q.size() == 0) chk("done_unexpected", ic_done_o ? 1 : 2, 0);
      else chk("done_owner", ic_done_o ? 1 : 2, done_q.pop_front());
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_req_o) begin
      if (beat_q.size() == 0) chk("beat_unexpected", mem_addr_o, 32'hFFFF_FFFF);
      else begin
        chk("mem_addr", mem_addr_o, beat_q[0].addr);
        chk("mem_we", 32'(mem_we_o), 32'(beat_q[0].we));
        if (beat_q[0].we) chk("mem_wdata", mem_wdata_o, beat_q[0].wdata);
        if (mem_ready_i) begin
          chk("ic_rvalid", 32'(ic_rvalid_o), 32'(!beat_q[0].we && beat_q[0].own == 1));
          chk("dc_rvalid", 32'(dc_rvalid_o), 32'(!beat_q[0].we && beat_q[0].own == 2));
          chk("dc_wready", 32'(dc_wready_o), 32'(beat_q[0].we));
          if (!beat_q[0].we)
            chk("rdata", beat_q[0].own == 1 ? ic_rdata_o : dc_rdata_o, beat_q[0].addr ^ 32'h5A5A_0000);
          if (dc_rvalid_o) dc_rv_cnt++;
          if (dc_wready_o) wr_cnt++;
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
          void'(beat_q.pop_front());
          beats_done++;
        end else begin
          chk("stall_strobes", {29'd0, ic_rvalid_o, dc_rvalid_o, dc_wready_o}, 0);
          if (ready_mode == 2) stall_seen++;
        end
      end
    end else chk("idle_strobes", {29'd0, ic_rvalid_o, dc_rvalid_o, dc_wready_o}, 0);
  end

  initial begin
    int w0, r0, d0, b;
    #3;
    chk("reset_ctrl", {23'd0, ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o,
                       dc_wready_o, dc_done_o, mem_req_o, mem_we_o}, 0);
    chk("reset_addr", mem_addr_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;
    // 1: Icache alone, ready always high
    ic_addr_i = 32'h14; ic_req_i = 1; push_burst(1, 0, 32'h14);
    wait_dones(1);
    ic_req_i = 0;
    chk("t1_first_beat", 32'(first_beat_cyc - gnt_cyc), 1);
    chk("t1_done", 32'(done_cyc - gnt_cyc), 5);
    // 2: Dcache writeback, ready every other cycle
    ready_mode = 1; w0 = wr_cnt; d0 = done_cnt;
    dc_addr_i = 32'h100; dc_we_i = 1; dc_req_i = 1; push_burst(2, 1, 32'h100);
    wait_dones(1);
    dc_req_i = 0; dc_we_i = 0;
    chk("t2_wready_cnt", 32'(wr_cnt - w0), 4);
    chk("t2_done_cnt", 32'(done_cnt - d0), 1);
    // 4: Dcache refill stalled 5 cycles on beat 2
    ready_mode = 2; stall_at = beats_done + 2; stall_n = 0; stall_seen = 0; r0 = dc_rv_cnt;
    dc_addr_i = 32'h204; dc_req_i = 1; push_burst(2, 0, 32'h204);
    wait_dones(1);
    dc_req_i = 0; ready_mode = 0;
    chk("t4_stall_cycles", 32'(stall_seen), 5);
    chk("t4_rvalid_cnt", 32'(dc_rv_cnt - r0), 4);
    // 6: Icache drops its request after beat 0; burst must still finish
    b = beats_done + 1;
    ic_addr_i = 32'h300; ic_req_i = 1; push_burst(1, 0, 32'h300);
    wait_beats(b);
    ic_req_i = 0;
    wait_dones(1);
    dc_addr_i = 32'h404; dc_req_i = 1; push_burst(2, 0, 32'h404);
    wait_dones(1);
    dc_req_i = 0;
    // 3: both request continuously
    ic_addr_i = 32'h1000; dc_addr_i = 32'h2000;
    for (int i = 0; i < 8; i++) push_burst(i % 4 == 3 ? 1 : 2, 0, i % 4 == 3 ? 32'h1000 : 32'h2000);
    ic_req_i = 1; dc_req_i = 1;
    wait_dones(8);
    ic_req_i = 0; dc_req_i = 0;
    chk("t3_queue_drained", 32'(gnt_q.size()), 0);
    // 5: reset during beat 1 of an Icache burst
    b = beats_done + 1;
    ic_addr_i = 32'h40; ic_req_i = 1; push_burst(1, 0, 32'h40);
    wait_beats(b);
    rst_n = 0; d0 = done_cnt;
    #1;
    chk("t5_reset_ctrl", {23'd0, ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o,
                          dc_wready_o, dc_done_o, mem_req_o, mem_we_o}, 0);
    chk("t5_reset_data", mem_addr_o | ic_rdata_o | dc_rdata_o | mem_wdata_o, 0);
    beat_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("t5_no_done", done_cnt, d0);
    ic_req_i = 0;
    dc_addr_i = 32'h80; dc_req_i = 1; push_burst(2, 0, 32'h80);
    rst_n = 1;
    wait_dones(1);
    dc_req_i = 0;
    repeat (3) @(posedge clk);
    chk("final_beats_left", 32'(beat_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
